// File: rtl/clz_norm_sequencer_pkg.sv
// fpu_norm_pkg: shared types, constants and reference helper for the mantissa normaliser
package fpu_norm_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} norm_state_t;

    function automatic logic [2:0] clz_nibble(input logic [3:0] d);
        return d[3] ? 3'd0 : d[2] ? 3'd1 : d[1] ? 3'd2 : d[0] ? 3'd3 : 3'd4;
    endfunction

endpackage

// File: rtl/clz_norm_sequencer_clz_4.sv
// clz_4: leading-zero count of a single nibble, 0..4
module clz_4 (
    input  logic [3:0] data_i,
    output logic [2:0] count_o
);

    // priority encode from the MSB down; all-zero nibble reports 4
    always_comb
        count_o = data_i[3] ? 3'd0 : data_i[2] ? 3'd1 : data_i[1] ? 3'd2 : data_i[0] ? 3'd3 : 3'd4;

endmodule

// File: rtl/clz_norm_sequencer.sv
// clz_norm_sequencer: nibble-serial leading-zero normaliser with valid/ready handshakes
module clz_norm_sequencer
    import fpu_norm_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    norm_state_t      state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_zero_q, out_zero_d;
    logic [2:0]       nz;
    logic             last_nibble;
    logic             scan_more;

    clz_4 u_clz (
        .data_i  (work_q[WIDTH-1 -: NIBBLE]),
        .count_o (nz)
    );

    // the final nibble is reached once WIDTH-4 zeros have been consumed
    assign last_nibble = cnt_q == CNT_W'(WIDTH - NIBBLE);
    assign scan_more   = nz == 3'd4 && !last_nibble;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    // next-state: flush overrides every handshake
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = in_valid ? SCAN : IDLE;
        else if (state_q == SCAN)
            state_d = scan_more ? SCAN : DONE;
        else if (state_q == DONE)
            state_d = out_ready ? IDLE : DONE;
    end

    // handshake outputs decoded from the registered state
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end

    // datapath next-state: capture on accept, shift per nibble, latch result on the final scan
    always_comb begin
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;
        if (flush)
            out_zero_d = 1'b0;
        else if (state_q == IDLE && in_valid) begin
            work_d = in_data;
            cnt_d  = '0;
        end else if (state_q == SCAN && scan_more) begin
            work_d = work_q << NIBBLE;
            cnt_d  = cnt_q + CNT_W'(NIBBLE);
        end else if (state_q == SCAN) begin
            out_data_d  = work_q << nz;
            out_count_d = cnt_q + CNT_W'(nz);
            out_zero_d  = nz == 3'd4;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            work_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_clz_norm_sequencer.sv
// tb_clz_norm_sequencer: table-driven vectors with a result scoreboard plus abort/back-pressure sequences
module tb_clz_norm_sequencer;

    localparam int WIDTH = 24;
    localparam int CNT_W = 5;

    typedef struct {
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        int               cnt;
        bit               zero;
        int               scans;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[8];
    vec_t sb[$];

    clz_norm_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] d);
        int t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 24'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string nm, input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            chk({nm, "_scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_scans"}, 32'(lat), 32'(e.scans));
        chk({nm, "_data"}, 32'(out_data), 32'(e.dout));
        chk({nm, "_count"}, 32'(out_count), 32'(e.cnt));
        chk({nm, "_zero"}, 32'(out_zero), 32'(e.zero));
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_cleared"}, 32'(out_valid), 32'd0);
        chk({nm, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        sb.push_back(v);
        start_op(v.din);
        wait_valid(lat);
        check_result(nm, lat);
        handshake(nm);
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [WIDTH-1:0] held_data;
        logic [CNT_W-1:0] held_count;
        vecs[0] = '{24'h800000, 24'h800000, 0,  1'b0, 1};
        vecs[1] = '{24'h001234, 24'h91A000, 11, 1'b0, 3};
        vecs[2] = '{24'h000001, 24'h800000, 23, 1'b0, 6};
        vecs[3] = '{24'h000000, 24'h000000, 24, 1'b1, 6};
        vecs[4] = '{24'hFFFFFF, 24'hFFFFFF, 0,  1'b0, 1};
        vecs[5] = '{24'h0F0000, 24'hF00000, 4,  1'b0, 2};
        vecs[6] = '{24'h000010, 24'h800000, 19, 1'b0, 5};
        vecs[7] = '{24'h123456, 24'h91A2B0, 3,  1'b0, 1};

        repeat (2) tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_out_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // back-pressure: hold the result while a stray operand is offered
        sb.push_back(vecs[1]);
        start_op(vecs[1].din);
        wait_valid(lat);
        check_result("bp", lat);
        in_valid = 1'b1;
        in_data  = 24'h800000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_hold%0d_data", i), 32'(out_data), 32'h91A000);
            chk($sformatf("bp_hold%0d_count", i), 32'(out_count), 32'd11);
        end
        in_valid = 1'b0;
        handshake("bp");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_ignored%0d", i), 32'(out_valid), 32'd0);
        end

        // flush during the second scan cycle of 0x000001
        held_data  = out_data;
        held_count = out_count;
        start_op(24'h000001);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", 32'(in_ready), 32'd1);
        chk("flush_no_valid", 32'(out_valid), 32'd0);
        chk("flush_hold_data", 32'(out_data), 32'(held_data));
        chk("flush_hold_count", 32'(out_count), 32'(held_count));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("flush_quiet%0d", i), 32'(out_valid), 32'd0);
        end
        v = '{24'h400000, 24'h800000, 1, 1'b0, 1};
        run_vec(v, "after_flush");

        // asynchronous reset during the second scan cycle of 0x000001
        start_op(24'h000001);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_count", 32'(out_count), 32'd0);
        chk("rst_mid_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rst_quiet%0d", i), 32'(out_valid), 32'd0);
        end
        run_vec(v, "after_reset");

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
